// File: rtl/vid_dma_pkg.sv
// vid_dma_pkg: shared constants, state encoding and helpers for the video DMA prefetch engine.
// Revision 1.0
`default_nettype none

package vid_dma_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  localparam int BURST_BEATS = 4;
  localparam int GAP_CYCLES  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_BURST = 2'd2,
    ST_GAP   = 2'd3
  } vid_dma_state_t;

  function automatic logic [23:0] align16(input logic [23:0] a);
    return {a[23:4], 4'b0000};
  endfunction

endpackage

`default_nettype wire

// File: rtl/vid_dma_fifo.sv
// vid_dma_fifo: single-clock FIFO with registered read port; flush overrides push and pop.
// Revision 1.0
`default_nettype none

module vid_dma_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
  output logic [$clog2(DEPTH):0]   count
);
  import vid_dma_pkg::*;

  localparam int          AW     = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !flush && (cnt != C_FULL);
  assign do_pop  = pop && !flush && (cnt != '0);
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // dout keeps its last value on an empty pop so the shifter sees stable data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= do_pop;
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout   <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/vid_dma_fetch.sv
// vid_dma_fetch: Wishbone 4-beat burst prefetcher feeding a word FIFO for the video shifter.
// Optional underrun counter port enabled by defining VID_DMA_UNDERRUN_EN. Revision 1.0
`default_nettype none

module vid_dma_fetch #(
  parameter int FIFO_DEPTH  = 16,
  parameter int BURST_BEATS = 4
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic        dma_start,
  input  logic [23:0] dma_base,
  input  logic [15:0] dma_words,
  output logic        dma_busy,
  output logic        dma_done,
  input  logic        pix_rd,
  output logic [31:0] pix_data,
  output logic        pix_valid,
  output logic        pix_empty,
  output logic [23:0] wb_adr,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [3:0]  wb_sel,
  output logic [2:0]  wb_cti,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack
`ifdef VID_DMA_UNDERRUN_EN
  ,
  output logic [15:0] underrun_cnt
`endif
);
  import vid_dma_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  vid_dma_state_t state_q, state_d;
  logic [23:0]    addr_q, addr_d;
  logic [13:0]    remain_q, remain_d;
  logic [1:0]     beat_q, beat_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic           discard_q, discard_d;
  logic           cyc_q, cyc_d;
  logic [2:0]     cti_q, cti_d;
  logic [23:0]    adr_q, adr_d;
  logic           done_q, done_d;

  logic           fifo_push;
  logic           fifo_flush;
  logic [CW-1:0]  fifo_count;
  logic           space_ok;
  logic           ack_ok;
  logic           last_beat;
  logic [23:0]    new_addr;
  logic [13:0]    new_remain;
  logic           unused_bits;

  assign unused_bits = ^{dma_base[3:0], dma_words[1:0]};

  assign new_addr   = align16(dma_base);
  assign new_remain = dma_words[15:2];
  assign space_ok   = (CW'(FIFO_DEPTH) - fifo_count) >= CW'(BURST_BEATS);
  assign ack_ok     = wb_ack && cyc_q;
  assign last_beat  = ack_ok && (beat_q == 2'(BURST_BEATS - 1));

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      remain_q  <= '0;
      beat_q    <= '0;
      gap_q     <= '0;
      discard_q <= 1'b0;
      cyc_q     <= 1'b0;
      cti_q     <= CTI_CLASSIC;
      adr_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      remain_q  <= remain_d;
      beat_q    <= beat_d;
      gap_q     <= gap_d;
      discard_q <= discard_d;
      cyc_q     <= cyc_d;
      cti_q     <= cti_d;
      adr_q     <= adr_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    beat_d     = beat_q;
    gap_d      = gap_q;
    discard_d  = discard_q;
    cyc_d      = cyc_q;
    cti_d      = cti_q;
    adr_d      = adr_q;
    done_d     = 1'b0;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;

    if (dma_start && (state_q != ST_BURST)) begin
      // Outside a bus burst a restart takes effect immediately.
      fifo_flush = 1'b1;
      addr_d     = new_addr;
      remain_d   = new_remain;
      if (new_remain == '0) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = ST_ARM;
      end
    end else begin
      case (state_q)
        ST_ARM: begin
          if (space_ok) begin
            cyc_d   = 1'b1;
            cti_d   = CTI_INCR;
            adr_d   = addr_q;
            beat_d  = '0;
            state_d = ST_BURST;
          end
        end
        ST_BURST: begin
          if (ack_ok) begin
            fifo_push = !discard_q;
            beat_d    = beat_q + 1'b1;
          end
          if (last_beat) begin
            cyc_d     = 1'b0;
            cti_d     = CTI_CLASSIC;
            gap_d     = '0;
            discard_d = 1'b0;
            state_d   = ST_GAP;
            if (!discard_q && !dma_start) begin
              addr_d   = addr_q + 24'd16;
              remain_d = remain_q - 1'b1;
              done_d   = (remain_q == 14'd1);
            end
          end
          // The controller cannot abort a burst: drain it, dropping the rest.
          if (dma_start) begin
            fifo_flush = 1'b1;
            addr_d     = new_addr;
            remain_d   = new_remain;
            discard_d  = !last_beat;
          end
        end
        ST_GAP: begin
          if (gap_q == GW'(GAP_CYCLES - 1)) begin
            state_d = (remain_q != '0) ? ST_ARM : ST_IDLE;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  vid_dma_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk        (wb_clk),
    .rst_n      (wb_rst_n),
    .flush      (fifo_flush),
    .push       (fifo_push),
    .din        (wb_dat_i),
    .pop        (pix_rd),
    .dout       (pix_data),
    .dout_valid (pix_valid),
    .count      (fifo_count)
  );

`ifdef VID_DMA_UNDERRUN_EN
  logic [15:0] underrun_q;

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      underrun_q <= '0;
    end else if (dma_start) begin
      underrun_q <= '0;
    end else if (pix_rd && (fifo_count == '0) && (underrun_q != 16'hFFFF)) begin
      underrun_q <= underrun_q + 16'd1;
    end
  end

  assign underrun_cnt = underrun_q;
`endif

  assign dma_busy  = (state_q != ST_IDLE);
  assign dma_done  = done_q;
  assign pix_empty = (fifo_count == '0);
  assign wb_adr    = adr_q;
  assign wb_cyc    = cyc_q;
  assign wb_stb    = cyc_q;
  assign wb_we     = 1'b0;
  assign wb_sel    = 4'hF;
  assign wb_cti    = cti_q;

endmodule

`default_nettype wire

// File: doc/vid_dma_fetch.md
# vid_dma_fetch

Video DMA prefetch engine in the `wb_clk` domain. It issues 4-beat incrementing Wishbone burst reads to the SDRAM controller, which acts as the Wishbone slave. The returned 32-bit words are buffered in a small FIFO that the video shifter drains one word at a time. It sits directly upstream of the SDRAM controller's chipset port and replaces single-word video fetches, making full use of the controller's 8×16-bit read burst.

## Interface
- `FIFO_DEPTH`, 16: FIFO depth in 32-bit words; power of two, ≥ 8.
- `BURST_BEATS`, 4: words per burst. Fixed to match the controller's burst; other values are illegal.
- `wb_clk` in 1: sole clock, 32 MHz chipset clock.
- `wb_rst_n` in 1: reset, **synchronous, active-low**.
- `dma_start` in 1: single-cycle pulse; latches `dma_base`/`dma_words` and starts (or restarts) a transfer.
- `dma_base` in 24: byte start address; bits [3:0] ignored (16-byte aligned).
- `dma_words` in 16: words to fetch; bits [1:0] ignored (multiple of 4); 0 means no fetch.
- `dma_busy` out 1: transfer in progress or a burst still on the bus.
- `dma_done` out 1: one-cycle pulse when the last word of a transfer is written into the FIFO.
- `pix_rd` in 1: pop request from the video shifter.
- `pix_data` out 32: popped word.
- `pix_valid` out 1: `pix_data` is valid this cycle.
- `pix_empty` out 1: FIFO empty.
- `wb_adr` out 24: burst base address.
- `wb_cyc` out 1: Wishbone cycle.
- `wb_stb` out 1: Wishbone strobe.
- `wb_we` out 1: tied 0.
- `wb_sel` out 4: tied 4'hF.
- `wb_cti` out 3: cycle type.
- `wb_dat_i` in 32: read data from the controller.
- `wb_ack` in 1: acknowledge from the controller.

## Operation
- States: IDLE, ARM, BURST, GAP.
- IDLE: on `dma_start`, latch `addr = {dma_base[23:4],4'b0}` and `remain = dma_words[15:2]` (bursts); flush the FIFO; go to ARM. If `remain` = 0, stay in IDLE and pulse `dma_done`.
- ARM: when `FIFO_DEPTH - count ≥ 4`, assert `wb_cyc`, `wb_stb`, `wb_cti = 3'b010`, `wb_adr = addr`; go to BURST.
- BURST: hold `wb_adr` constant; count `wb_ack` beats 0..3; push `wb_dat_i` into the FIFO on each ack unless `discard` is set. On the 4th ack, register `wb_cyc`/`wb_stb` low, set `wb_cti = 3'b000`, `addr += 16`, `remain -= 1`, and go to GAP.
- GAP: hold the bus idle for 2 cycles, so the controller sees the request fall before the next rising request edge. Then go to ARM if `remain ≠ 0`, else IDLE.
- `dma_done` fires on the cycle the final beat is pushed. It is suppressed when `discard` is set.
- Restart mid-transfer (`dma_start` outside IDLE):
  - In ARM or GAP: flush the FIFO, reload `addr`/`remain`, go to ARM.
  - In BURST: the bus burst must complete (the controller cannot abort). Set `discard`, flush the FIFO, and latch the new parameters. Remaining beats are dropped. `discard` clears on entry to GAP, and the new transfer begins after GAP.
- Pop: `pix_rd` with `count > 0` gives `pix_data`/`pix_valid` on the next cycle (registered).
  - `pix_rd` while empty: `pix_valid = 0`, `pix_data` holds its previous value; this is an underrun.
- Simultaneous push and pop: `count` is unchanged. Pushes never overflow, because of the ARM space check.
- Address arithmetic is 24-bit and wraps modulo 2^24 with no error.

## Timing
- Reset values:
  - All Wishbone outputs 0 (`wb_sel` stays 4'hF).
  - `dma_busy = 0`, `dma_done = 0`.
  - `pix_valid = 0`, `pix_data = 0`, `pix_empty = 1`.
  - FIFO pointers 0, state IDLE, `discard = 0`.
- A reset mid-burst drops `wb_cyc` the next cycle. The controller finishes its burst internally, and its acks arrive with `wb_cyc` low and are ignored.
- From `dma_start` at cycle n: ARM at n+1, `wb_cyc`/`wb_stb` high at n+2 if the FIFO has space.
- The controller produces beats 2–4 on consecutive cycles after beat 1.
- Minimum burst-to-burst spacing: 4 acks + 2 GAP + 1 ARM cycles.
- `dma_busy` is high from the cycle after `dma_start` until IDLE is re-entered.

## Configuration
- `VID_DMA_UNDERRUN_EN`:
  - Defined: adds output `underrun_cnt` [15:0]. It increments (saturating at 16'hFFFF) on every `pix_rd` while empty, and clears on `dma_start` and on reset.
  - Undefined: the port and counter are absent, and underruns are silent.

## Structure
- Package `vid_dma_pkg`:
  - `CTI_CLASSIC = 3'b000`, `CTI_INCR = 3'b010`, `CTI_END = 3'b111` (reserved).
  - `BURST_BEATS = 4`, `GAP_CYCLES = 2`.
  - State enum `vid_dma_state_t`.
- Sub-module `vid_dma_fifo`: synchronous single-clock FIFO.
  - Ports: `push`, `din`, `pop`, `dout`, `count`, `flush`.
  - Registered read; `flush` has priority over `push`/`pop`.

## Test plan
- Reset, then `dma_start` with base 24'h010008 and words 8 → two bursts at `wb_adr` 24'h010000 then 24'h010010, each holding `wb_cti = 010` for 4 acks; 8 words popped in order; `dma_done` once.
- `dma_words` = 0 → no `wb_cyc`; `dma_done` pulses the cycle after `dma_start`; `dma_busy` stays 0.
- `FIFO_DEPTH` = 16, 64 words, no pops → `count` stops at 16 and the engine waits in ARM; popping 4 words triggers the next burst.
- `dma_start` during beat 2 of a burst → beats 3–4 are not pushed; the FIFO is empty after the flush; the next burst is at the new base after the 2-cycle gap.
- `pix_rd` on an empty FIFO for 5 cycles → `pix_valid = 0`; with `VID_DMA_UNDERRUN_EN` defined, `underrun_cnt` = 5.
- `wb_rst_n` low during BURST → `wb_cyc`/`wb_stb` are 0 the next cycle; late acks cause no push; the FIFO is empty.
